// File: rtl/mul_req_ctrl.sv
// Execute-stage requester for the iterative 32x32 multiplier.
// Issues MULT/MULTU, stalls until the product returns, drains on flush.
module mul_req_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mul_valid_i,
    input  logic        mul_signed_i,
    input  logic [31:0] rs_data_i,
    input  logic [31:0] rt_data_i,
    input  logic        flush_i,
    input  logic        ready_i,
    input  logic [63:0] result_i,
    output logic        start_o,
    output logic        annul_o,
    output logic        signed_mul_o,
    output logic [31:0] opdata1_o,
    output logic [31:0] opdata2_o,
    output logic        stallreq_o,
    output logic        hilo_we_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam int CW = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
    localparam logic [CW-1:0] DRAIN_LD = CW'(DRAIN_CYCLES);

    typedef enum logic [1:0] {IDLE, BUSY, DONE, FLUSH} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          start_q, start_d;
    logic          annul_q, annul_d;
    logic          sgn_q, sgn_d;
    logic [31:0]   op1_q, op1_d;
    logic [31:0]   op2_q, op2_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;
    logic          issue;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            start_q <= 1'b0;
            annul_q <= 1'b0;
            sgn_q   <= 1'b0;
            op1_q   <= '0;
            op2_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
            annul_q <= annul_d;
            sgn_q   <= sgn_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign issue = (state_q == IDLE) && mul_valid_i && !flush_i;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (issue) state_d = BUSY;
            BUSY:    if (flush_i) state_d = FLUSH;
                     else if (ready_i) state_d = DONE;
            DONE:    state_d = IDLE;
            // Wait out the multiplier's end state before allowing a new issue
            FLUSH:   if (cnt_q == '0 && !ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        start_d = 1'b0;
        annul_d = 1'b0;
        cnt_d   = cnt_q;
        sgn_d   = sgn_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        unique case (state_q)
            IDLE: begin
                if (issue) begin
                    start_d = 1'b1;
                    sgn_d   = mul_signed_i;
                    op1_d   = rs_data_i;
                    op2_d   = rt_data_i;
                end
            end
            BUSY: begin
                start_d = 1'b1;
                if (flush_i) begin
                    start_d = 1'b0;
                    annul_d = 1'b1;
                    cnt_d   = DRAIN_LD;
                end else if (ready_i) begin
                    start_d = 1'b0;
                    hi_d    = result_i[63:32];
                    lo_d    = result_i[31:0];
                end
            end
            FLUSH: begin
                if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
            end
            default: ;
        endcase
    end

    assign start_o      = start_q;
    assign annul_o      = annul_q;
    assign signed_mul_o = sgn_q;
    assign opdata1_o    = op1_q;
    assign opdata2_o    = op2_q;
    assign hi_o         = hi_q;
    assign lo_o         = lo_q;
    assign hilo_we_o    = (state_q == DONE) && !flush_i;
    assign stallreq_o   = issue || (state_q == BUSY) ||
                          ((state_q == FLUSH) && mul_valid_i && !flush_i);

endmodule

// File: doc/mul_req_ctrl.md
# mul_req_ctrl

Execute-stage requester for the iterative 32x32 multiplier. It issues MULT/MULTU operations to the multiplier over its start/annul/ready handshake and holds the operands stable for the whole operation. It stalls the pipeline until the 64-bit product returns, then presents the product as a one-cycle HI/LO write. On a pipeline flush it cancels the operation and drains the multiplier back to its free state.

## Interface
Parameters:
- DRAIN_CYCLES, 2, minimum cycles start_o is held low after a flush before a new issue is allowed.

Ports:
- clk  in  1  clock. Single clock domain.
- rst  in  1  reset. Synchronous, active-high.
- mul_valid_i  in  1  EX holds a MULT/MULTU.
- mul_signed_i  in  1  1 = MULT, 0 = MULTU.
- rs_data_i  in  32  first operand.
- rt_data_i  in  32  second operand.
- flush_i  in  1  kill the instruction in EX.
- ready_i  in  1  product valid, from the multiplier.
- result_i  in  64  product, from the multiplier.
- start_o  out  1  start request to the multiplier (registered).
- annul_o  out  1  cancel request to the multiplier (registered).
- signed_mul_o  out  1  signedness, latched at issue.
- opdata1_o  out  32  latched rs operand.
- opdata2_o  out  32  latched rt operand.
- stallreq_o  out  1  pipeline stall request (combinational).
- hilo_we_o  out  1  HI/LO write strobe.
- hi_o  out  32  product[63:32].
- lo_o  out  32  product[31:0].

## Operation
- States: IDLE, BUSY, DONE, FLUSH.
- Reset: state is IDLE, drain counter is 0, and every registered output is 0.
- IDLE:
  - Condition to issue: mul_valid_i=1 and flush_i=0.
  - On issue: latch rs/rt/signed into opdata1_o/opdata2_o/signed_mul_o, set start_o<=1, go to BUSY.
  - ready_i is ignored in IDLE.
- BUSY:
  - start_o stays 1. opdata*/signed_mul_o are frozen, because the multiplier re-reads them for the final sign fix.
  - flush_i=1: start_o<=0, annul_o<=1 for one cycle, drain counter <= DRAIN_CYCLES, go to FLUSH. Flush takes priority over ready_i in the same cycle.
  - Otherwise, ready_i=1: {hi_o,lo_o}<=result_i, start_o<=0, go to DONE.
- DONE (one cycle):
  - hilo_we_o = (state==DONE) & ~flush_i.
  - start_o stays 0, so the multiplier returns to free. Next state is IDLE.
  - A new issue is never taken in DONE.
- FLUSH:
  - annul_o returns to 0 after its single cycle. start_o stays 0.
  - The counter decrements each cycle. Go to IDLE when the counter is 0 and ready_i=0.
  - This covers a flush while the multiplier is in the by-zero path: it passes through its end state and sees start low before a new issue.
- stallreq_o = (IDLE & mul_valid_i & ~flush_i) | BUSY | (FLUSH & mul_valid_i & ~flush_i).
  - It is low in DONE, so the instruction advances in the same cycle HI/LO is written.
- hi_o/lo_o keep the last captured product until the next capture. Reset clears them to 0.
- Sign correction is done inside the multiplier. This block never alters result_i.

## Timing
- Cycle 0: IDLE, mul_valid_i=1. stallreq_o=1 combinationally. start_o=1 from cycle 1.
- Nonzero operands with the team multiplier: ready_i is first high in cycle 36. DONE, hilo_we_o=1 and stallreq_o=0 in cycle 37. IDLE in cycle 38.
- Either operand zero: ready_i in cycle 4, hilo_we_o in cycle 5.
- General rule: hilo_we_o is high exactly one cycle after the first cycle ready_i is sampled high in BUSY, and for exactly one cycle.
- start_o is low from DONE onward, for at least one cycle between back-to-back operations. The earliest re-issue is IDLE in cycle 38, with start_o=1 in cycle 39.
- Flush in BUSY at cycle k:
  - annul_o=1 in cycle k+1 only.
  - IDLE no earlier than cycle k+1+DRAIN_CYCLES.
  - hilo_we_o is never asserted for the flushed operation.
- rst mid-operation: controller returns to IDLE next cycle with start_o=0. The multiplier shares rst and resets too.

## Test plan
- Unsigned, rs=0xFFFFFFFF, rt=0x00000002:
  - stallreq_o is high cycles 0–36.
  - hilo_we_o is high in cycle 37 only, with hi_o=0x00000001 and lo_o=0xFFFFFFFE.
- Signed, rs=0xFFFFFFFD (−3), rt=0x00000007:
  - hi_o=0xFFFFFFFF, lo_o=0xFFFFFFEB.
  - opdata1_o stays 0xFFFFFFFD through all of BUSY while rs_data_i changes to 0x12345678 after cycle 0.
- rs=0, rt=0x1234: ready_i in cycle 4, hilo_we_o in cycle 5, {hi_o,lo_o}=0.
- flush_i at cycle 10 during BUSY:
  - annul_o=1 in cycle 11 only, start_o=0 from cycle 11.
  - No hilo_we_o.
  - A new MULT presented in cycle 11 stalls until IDLE, then issues and returns the correct product.
- Flush in cycle 2 with a zero operand (multiplier on the by-zero path): no hilo_we_o. The next issue completes with the correct product.
- Back-to-back MULTU 3*5 then 7*9:
  - Two hilo_we_o pulses, with lo_o=15 then 63.
  - start_o is low for at least one cycle between them.
- rst asserted in cycle 20: all outputs are 0 the next cycle. A following issue completes normally.
